// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Holds the receive FSM state enum and default frame constants.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..baud_div, ticks on the last count.
// Ports: clk, rst (sync, high), enable, baud_div in; tick out.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  assign tick = enable && (div_cnt_q == baud_div);

  // >= so that a smaller baud_div written mid-count wraps at once
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (!enable || (div_cnt_q >= baud_div)) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sync, start qualify, mid-bit sampling, handshake.
// Ports: clk, rst, enable, baud_div, rx, rx_ready in; rx_data, rx_valid,
// rx_ferr, rx_perr, overrun, busy out. UART_RX_PARITY_EN adds even parity.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_ferr,
  output logic                 rx_perr,
  output logic                 overrun,
  output logic                 busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_BITS - 1);

  logic tick;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .baud_div (baud_div),
    .tick     (tick)
  );

  rx_state_e            state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic                 stop_bit_q, stop_bit_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_q, par_err_d;
  logic                 rx_perr_q, rx_perr_d;
`endif

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    rx_meta_d  = rx;
    rx_s_d     = rx_meta_q;
    stop_bit_d = stop_bit_q;
    done_d     = 1'b0;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ferr_d  = rx_ferr_q;
    overrun_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d  = par_err_q;
    rx_perr_d  = rx_perr_q;
`endif

    if (!enable) begin
      state_d   = IDLE;
      os_cnt_d  = '0;
      bit_cnt_d = '0;
    end else if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d  = START;
            os_cnt_d = '0;
          end
        end
        START: begin
          if (os_cnt_q == OS_HALF) begin
            if (!rx_s_q) begin
              state_d   = DATA;
              os_cnt_d  = '0;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (os_cnt_q == OS_LAST) begin
            shreg_d   = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            os_cnt_d  = '0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (os_cnt_q == OS_LAST) begin
            par_err_d = ^{shreg_q, rx_s_q};
            os_cnt_d  = '0;
            state_d   = STOP;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (os_cnt_q == OS_LAST) begin
            stop_bit_d = rx_s_q;
            done_d     = 1'b1;
            os_cnt_d   = '0;
            state_d    = IDLE;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // a completing frame may reload in the same cycle the old byte is taken
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_ferr_d  = ~stop_bit_q;
        rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        rx_perr_d  = par_err_q;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      stop_bit_q <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      stop_bit_q <= stop_bit_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= par_err_d;
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_ferr  = rx_ferr_q;
  assign overrun  = overrun_q;
  assign busy     = busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx_perr  = rx_perr_q;
`else
  assign rx_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at baud_div=3, 16x oversample.
// Each task drives one scenario and checks results inline.
module tb_uart_rx_ctrl;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_MIN = 672;
  localparam int LAT_MAX = 679;
`else
  localparam int LAT_MIN = 608;
  localparam int LAT_MAX = 615;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic        rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b1;
  logic        rx_ferr;
  logic        rx_perr;
  logic        overrun;
  logic        busy;

  uart_rx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8), .DIV_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .baud_div (baud_div),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_ferr  (rx_ferr),
    .rx_perr  (rx_perr),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int       vcyc = 0;
  int       got_cnt = 0;
  int       ovr_cnt = 0;
  int       rise_cyc = 0;
  logic     valid_prev = 1'b0;
  logic [7:0] got_data = 8'h00;
  logic     got_ferr = 1'b0;
  logic     got_perr = 1'b0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) vcyc <= vcyc + 1;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      got_cnt  <= got_cnt + 1;
      got_data <= rx_data;
      got_ferr <= rx_ferr;
      got_perr <= rx_perr;
    end
    if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
    if (rx_valid === 1'b1 && !valid_prev) rise_cyc <= cyc;
    valid_prev <= (rx_valid === 1'b1);
  end

  int errs = 0;
  int checks = 0;
  int start_cyc = 0;
`ifdef UART_RX_PARITY_EN
  logic par_force = 1'b0;
  logic par_val = 1'b0;
`endif

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input int stop_len);
    @(posedge clk);
    #1;
    rx = 1'b0;
    start_cyc = cyc;
    hold(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_force ? par_val : ^d;
    hold(BIT_CLKS);
`endif
    rx = stop_v;
    hold(stop_len);
    rx = 1'b1;
    hold(2 * BIT_CLKS);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks += 6;
    if (rx_data !== 8'h00) begin errs++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    if (rx_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    if (rx_ferr !== 1'b0) begin errs++; $display("FAIL reset_ferr got=%b exp=0", rx_ferr); end
    if (rx_perr !== 1'b0) begin errs++; $display("FAIL reset_perr got=%b exp=0", rx_perr); end
    if (overrun !== 1'b0) begin errs++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    hold(2);
    rst = 1'b0;
    hold(4);
  endtask

  task automatic test_clean();
    int gb, vb, ob, lat;
    gb = got_cnt; vb = vcyc; ob = ovr_cnt;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, BIT_CLKS);
    lat = rise_cyc - start_cyc;
    checks += 7;
    if (got_cnt - gb !== 1) begin errs++; $display("FAIL clean_count got=%0d exp=1", got_cnt - gb); end
    if (got_data !== 8'hA5) begin errs++; $display("FAIL clean_data got=%h exp=a5", got_data); end
    if (got_ferr !== 1'b0) begin errs++; $display("FAIL clean_ferr got=%b exp=0", got_ferr); end
    if (got_perr !== 1'b0) begin errs++; $display("FAIL clean_perr got=%b exp=0", got_perr); end
    if (vcyc - vb !== 1) begin errs++; $display("FAIL clean_vwidth got=%0d exp=1", vcyc - vb); end
    if (ovr_cnt - ob !== 0) begin errs++; $display("FAIL clean_ovr got=%0d exp=0", ovr_cnt - ob); end
    if (lat < LAT_MIN || lat > LAT_MAX) begin
      errs++;
      $display("FAIL clean_latency got=%0d exp=%0d..%0d", lat, LAT_MIN, LAT_MAX);
    end
  endtask

  task automatic test_glitch();
    int gb;
    gb = got_cnt;
    @(posedge clk);
    #1;
    rx = 1'b0;
    hold(12);
    checks++;
    if (busy !== 1'b1) begin errs++; $display("FAIL glitch_busy_hi got=%b exp=1", busy); end
    hold(8);
    rx = 1'b1;
    hold(60);
    checks += 2;
    if (busy !== 1'b0) begin errs++; $display("FAIL glitch_busy_lo got=%b exp=0", busy); end
    if (got_cnt - gb !== 0) begin errs++; $display("FAIL glitch_nodata got=%0d exp=0", got_cnt - gb); end
    send_frame(8'h3C, 1'b1, BIT_CLKS);
    checks += 2;
    if (got_cnt - gb !== 1) begin errs++; $display("FAIL glitch_next_cnt got=%0d exp=1", got_cnt - gb); end
    if (got_data !== 8'h3C) begin errs++; $display("FAIL glitch_next_data got=%h exp=3c", got_data); end
  endtask

  task automatic test_ferr();
    int gb;
    gb = got_cnt;
    send_frame(8'h5A, 1'b0, 44);
    checks += 3;
    if (got_cnt - gb !== 1) begin errs++; $display("FAIL ferr_count got=%0d exp=1", got_cnt - gb); end
    if (got_data !== 8'h5A) begin errs++; $display("FAIL ferr_data got=%h exp=5a", got_data); end
    if (got_ferr !== 1'b1) begin errs++; $display("FAIL ferr_flag got=%b exp=1", got_ferr); end
  endtask

  task automatic test_back_to_back();
    int gb, ob;
    gb = got_cnt; ob = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, BIT_CLKS);
    send_frame(8'h22, 1'b1, BIT_CLKS);
    checks += 4;
    if (rx_valid !== 1'b1) begin errs++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
    if (rx_data !== 8'h11) begin errs++; $display("FAIL ovr_data got=%h exp=11", rx_data); end
    if (ovr_cnt - ob !== 1) begin errs++; $display("FAIL ovr_pulse got=%0d exp=1", ovr_cnt - ob); end
    if (got_cnt - gb !== 0) begin errs++; $display("FAIL ovr_held got=%0d exp=0", got_cnt - gb); end
    rx_ready = 1'b1;
    hold(2);
    checks += 2;
    if (rx_valid !== 1'b0) begin errs++; $display("FAIL ovr_drain got=%b exp=0", rx_valid); end
    if (got_data !== 8'h11) begin errs++; $display("FAIL ovr_taken got=%h exp=11", got_data); end
  endtask

  task automatic test_rst_mid();
    int gb;
    logic [7:0] d;
    gb = got_cnt;
    d = 8'h5A;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      hold(BIT_CLKS);
    end
    rx = d[4];
    hold(BIT_CLKS / 2);
    rst = 1'b1;
    hold(1);
    checks += 5;
    if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    if (rx_valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid got=%b exp=0", rx_valid); end
    if (rx_data !== 8'h00) begin errs++; $display("FAIL rstmid_data got=%h exp=00", rx_data); end
    if (rx_ferr !== 1'b0) begin errs++; $display("FAIL rstmid_ferr got=%b exp=0", rx_ferr); end
    if (overrun !== 1'b0) begin errs++; $display("FAIL rstmid_ovr got=%b exp=0", overrun); end
    rst = 1'b0;
    rx = 1'b1;
    hold(11 * BIT_CLKS);
    checks += 2;
    if (got_cnt - gb !== 0) begin errs++; $display("FAIL rstmid_nodata got=%0d exp=0", got_cnt - gb); end
    if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_idle got=%b exp=0", busy); end
  endtask

  task automatic test_enable_mid();
    int ob;
    logic [7:0] d;
    d = 8'h99;
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b1, BIT_CLKS);
    ob = ovr_cnt;
    checks++;
    if (rx_valid !== 1'b1) begin errs++; $display("FAIL en_pending got=%b exp=1", rx_valid); end
    @(posedge clk);
    #1;
    rx = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      hold(BIT_CLKS);
    end
    rx = d[4];
    hold(BIT_CLKS / 2);
    enable = 1'b0;
    hold(2);
    checks += 3;
    if (busy !== 1'b0) begin errs++; $display("FAIL en_busy got=%b exp=0", busy); end
    if (rx_valid !== 1'b1) begin errs++; $display("FAIL en_valid got=%b exp=1", rx_valid); end
    if (rx_data !== 8'h77) begin errs++; $display("FAIL en_data got=%h exp=77", rx_data); end
    rx = 1'b1;
    hold(4);
    enable = 1'b1;
    hold(11 * BIT_CLKS);
    checks += 2;
    if (ovr_cnt - ob !== 0) begin errs++; $display("FAIL en_noovr got=%0d exp=0", ovr_cnt - ob); end
    if (rx_data !== 8'h77) begin errs++; $display("FAIL en_kept got=%h exp=77", rx_data); end
    rx_ready = 1'b1;
    hold(2);
    checks += 2;
    if (got_data !== 8'h77) begin errs++; $display("FAIL en_taken got=%h exp=77", got_data); end
    if (rx_valid !== 1'b0) begin errs++; $display("FAIL en_drain got=%b exp=0", rx_valid); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    rx_ready = 1'b1;
    par_force = 1'b1;
    par_val = 1'b0;
    send_frame(8'h0F, 1'b1, BIT_CLKS);
    checks += 2;
    if (got_data !== 8'h0F) begin errs++; $display("FAIL par0_data got=%h exp=0f", got_data); end
    if (got_perr !== 1'b0) begin errs++; $display("FAIL par0_perr got=%b exp=0", got_perr); end
    par_val = 1'b1;
    send_frame(8'h0F, 1'b1, BIT_CLKS);
    checks++;
    if (got_perr !== 1'b1) begin errs++; $display("FAIL par1_perr got=%b exp=1", got_perr); end
    send_frame(8'h07, 1'b1, BIT_CLKS);
    checks += 2;
    if (got_data !== 8'h07) begin errs++; $display("FAIL par2_data got=%h exp=07", got_data); end
    if (got_perr !== 1'b0) begin errs++; $display("FAIL par2_perr got=%b exp=0", got_perr); end
    par_force = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
    test_glitch();
    test_ferr();
    test_back_to_back();
    test_rst_mid();
    test_enable_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Sequencing controller for the UART receive path.
- Generates the oversample tick from a programmable divider and synchronises the serial line.
- Detects and qualifies the start bit, then strobes mid-bit sampling of data and stop bits into an LSB-first shift register.
- Presents each completed byte on a valid/ready handshake with framing and overrun status. It sits between the `rx` pin and the consumer (FIFO or bus interface).

Parameters:
- OVERSAMPLE, 16, oversample ticks per bit; must be even and ≥4.
- DATA_BITS, 8, data bits per frame.
- DIV_W, 16, width of the baud divider input.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, receiver enable; low forces the FSM to IDLE.
- baud_div, input, DIV_W, clocks per oversample tick minus 1.
- rx, input, 1, asynchronous serial line; idle level is 1.
- rx_data, output, DATA_BITS, received byte.
- rx_valid, output, 1, byte available.
- rx_ready, input, 1, consumer accepts the byte.
- rx_ferr, output, 1, framing error, qualified by rx_valid.
- rx_perr, output, 1, parity error, qualified by rx_valid.
- overrun, output, 1, one-cycle pulse when a completed frame is dropped.
- busy, output, 1, high when the FSM state is not IDLE.

Behaviour:
- Reset: all of the following hold these values on the first clk edge with rst=1.
  - rx_data=0, rx_valid=0, rx_ferr=0, rx_perr=0, overrun=0, busy=0.
  - FSM is IDLE; divider, oversample and bit counters are 0.
  - Synchroniser flops are 1.
- Reset mid-frame discards the partial frame.
- Synchroniser: a 2-flop chain gives rx_s, so rx_s lags rx by 2 cycles.
- Tick:
  - div_cnt counts 0..baud_div; tick=1 on the cycle div_cnt==baud_div, after which div_cnt wraps to 0.
  - baud_div=0 gives a tick every cycle.
  - div_cnt is held at 0 while enable=0.
- FSM: all transitions occur only on tick cycles. os_cnt counts ticks and bit_cnt counts data bits.
  - IDLE: if rx_s==0, go to START with os_cnt=0.
  - START: os_cnt increments each tick. At os_cnt==OVERSAMPLE/2-1:
    - if rx_s==0, go to DATA with os_cnt=0 and bit_cnt=0;
    - otherwise treat it as a glitch and return to IDLE.
  - DATA: at os_cnt==OVERSAMPLE-1:
    - shift rx_s into the MSB of shreg (shift right, so the frame is received LSB first);
    - set os_cnt=0 and increment bit_cnt;
    - after bit DATA_BITS-1, go to PARITY (when PARITY_EN is defined) or STOP.
  - STOP: at os_cnt==OVERSAMPLE-1, sample rx_s, complete the frame, and go to IDLE. The next start bit can therefore be detected from mid-stop onward.
- Completion, on the cycle after the stop sample:
  - If rx_valid==0, or rx_valid&&rx_ready in the same cycle:
    - rx_data<=shreg; rx_ferr<=~stop_sample; rx_perr<=parity result; rx_valid<=1.
  - Otherwise:
    - rx_data, rx_ferr and rx_perr are unchanged; overrun=1 for one cycle; the new frame is dropped.
- Handshake: rx_valid stays high until sampled with rx_ready=1; it clears on the next edge unless a completion loads new data in that same cycle.
- rx_ready with rx_valid=0 is ignored.
- enable=0 mid-frame: the FSM returns to IDLE next cycle and the partial frame is discarded. A pending rx_valid and its data are retained.
- A change of baud_div mid-frame takes effect at the next div_cnt wrap; no other guarantee is given.
- Frame latency is start-bit falling edge to rx_valid: (DATA_BITS+1.5)·OVERSAMPLE·(baud_div+1) clocks, plus ≤(baud_div+1)+3 cycles, without parity.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples at os_cnt==OVERSAMPLE-1.
  - Even parity is checked: rx_perr=^{shreg, parity_sample}.
  - Latency grows by OVERSAMPLE·(baud_div+1).
- Undefined:
  - No PARITY state exists; rx_perr is tied to 0.
  - The port list is identical in both builds.

Decomposition:
- uart_pkg holds:
  - the FSM state enum: IDLE, START, DATA, PARITY, STOP;
  - default constants: OVERSAMPLE_DEF=16, DATA_BITS_DEF=8.
- Sub-module uart_baud_tick contains the divider counter and enable gating, and outputs tick.
- The synchroniser, FSM, shift register and handshake live in uart_rx_ctrl.

Test Plan:
- Clean frame: baud_div=3, OVERSAMPLE=16 (64 clocks/bit), rx sends 0xA5 with stop=1, rx_ready=1 → rx_data=0xA5, rx_valid high for exactly 1 cycle, rx_ferr=0, overrun=0, latency within bound.
- Glitch: rx low for 20 clocks (< half bit), then high → busy rises then falls, no rx_valid; a following 0x3C frame is received correctly.
- Framing error: 0x5A sent with stop bit=0 → rx_data=0x5A, rx_valid=1, rx_ferr=1.
- Overrun: rx_ready=0, back-to-back frames 0x11 then 0x22 → rx_data stays 0x11 and a one-cycle overrun pulse occurs at the second completion; raising rx_ready then clears rx_valid.
- Reset/enable mid-frame:
  - rst pulsed at bit 4 of a frame → all outputs 0, nothing delivered.
  - enable dropped at bit 4 with 0x77 pending → rx_valid=1 and rx_data=0x77 retained.
- Parity (UART_RX_PARITY_EN): 0x0F with parity=0 → rx_perr=0; 0x0F with parity=1 → rx_perr=1; 0x07 with parity=1 → rx_perr=0.
